// File: rtl/chain_checker.sv
// Far-end checker for one delay chain: flushes it, measures probe latency,
// then streams PRBS-7 through it and counts bit errors.
module chain_checker #(
   parameter int MAX_LAT  = 255,
   parameter int LAT_W    = 8,
   parameter int TEST_LEN = 1024,
   parameter int ERR_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             chain_dout,
   output logic             chain_din,
   output logic             busy,
   output logic             done,
   output logic [LAT_W-1:0] latency,
   output logic [ERR_W-1:0] err_cnt,
   output logic             timeout,
   output logic             stuck
);

   localparam int CAP_W = $clog2(TEST_LEN + 1);
   localparam logic [LAT_W-1:0] LAT_MAX   = LAT_W'(MAX_LAT);
   localparam logic [LAT_W-1:0] LAT_ONE   = LAT_W'(1'b1);
   localparam logic [CAP_W-1:0] CAP_ONE   = CAP_W'(1'b1);
   localparam logic [CAP_W-1:0] CAP_CHK   = CAP_W'(3'd7);
   localparam logic [CAP_W-1:0] CAP_LAST  = CAP_W'(TEST_LEN - 1);
   localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1'b1);
   localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};
   localparam logic [6:0]       PRBS_SEED = 7'h7F;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FLUSH = 3'd1,
      S_PROBE = 3'd2,
      S_WAIT  = 3'd3,
      S_PRBS  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t             state_r;
   logic [LAT_W-1:0]   cnt_r;
   logic [LAT_W-1:0]   ph_r;
   logic [CAP_W-1:0]   cap_r;
   logic [6:0]         gen_r;
   logic [6:0]         rx_r;
   logic               chain_din_r;
   logic               busy_r;
   logic               done_r;
   logic [LAT_W-1:0]   latency_r;
   logic [ERR_W-1:0]   err_cnt_r;
   logic               timeout_r;
   logic               stuck_r;

   // x^7 + x^6 + 1 feedback tap and one generator step
   function automatic logic prbs_fb(input logic [6:0] v);
      return v[6] ^ v[5];
   endfunction

   function automatic logic [6:0] prbs_step(input logic [6:0] v);
      return {v[5:0], prbs_fb(v)};
   endfunction

   // Run sequencer: state, counters, PRBS generator/receiver and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= S_IDLE;
         cnt_r       <= '0;
         ph_r        <= '0;
         cap_r       <= '0;
         gen_r       <= '0;
         rx_r        <= '0;
         chain_din_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         latency_r   <= '0;
         err_cnt_r   <= '0;
         timeout_r   <= 1'b0;
         stuck_r     <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE, S_DONE: begin
               chain_din_r <= 1'b0;
               if (start) begin
                  state_r   <= S_FLUSH;
                  busy_r    <= 1'b1;
                  done_r    <= 1'b0;
                  cnt_r     <= '0;
                  ph_r      <= '0;
                  cap_r     <= '0;
                  gen_r     <= '0;
                  rx_r      <= '0;
                  latency_r <= '0;
                  err_cnt_r <= '0;
                  timeout_r <= 1'b0;
                  stuck_r   <= 1'b0;
               end
            end
            S_FLUSH: begin
               chain_din_r <= 1'b0;
               if (cnt_r == LAT_MAX) begin
                  cnt_r <= '0;
                  if (chain_dout) begin
                     stuck_r <= 1'b1;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                     state_r <= S_DONE;
                  end else begin
                     state_r <= S_PROBE;
                  end
               end else begin
                  cnt_r <= cnt_r + LAT_ONE;
               end
            end
            S_PROBE: begin
               chain_din_r <= 1'b1;
               cnt_r       <= '0;
               state_r     <= S_WAIT;
            end
            // Detection is tested before the limit so a probe seen at MAX_LAT still counts
            S_WAIT: begin
               chain_din_r <= 1'b0;
               if (chain_dout) begin
                  latency_r   <= cnt_r;
                  chain_din_r <= prbs_fb(PRBS_SEED);
                  gen_r       <= prbs_step(PRBS_SEED);
                  ph_r        <= '0;
                  cap_r       <= '0;
                  state_r     <= S_PRBS;
               end else if (cnt_r == LAT_MAX) begin
                  timeout_r <= 1'b1;
                  latency_r <= LAT_MAX;
                  busy_r    <= 1'b0;
                  done_r    <= 1'b1;
                  state_r   <= S_DONE;
               end else begin
                  cnt_r <= cnt_r + LAT_ONE;
               end
            end
            S_PRBS: begin
               chain_din_r <= prbs_fb(gen_r);
               gen_r       <= prbs_step(gen_r);
               if (ph_r >= latency_r) begin
                  rx_r <= {rx_r[5:0], chain_dout};
                  if ((cap_r >= CAP_CHK) && (chain_dout != prbs_fb(rx_r))
                      && (err_cnt_r != ERR_MAX)) begin
                     err_cnt_r <= err_cnt_r + ERR_ONE;
                  end
                  if (cap_r == CAP_LAST) begin
                     chain_din_r <= 1'b0;
                     busy_r      <= 1'b0;
                     done_r      <= 1'b1;
                     state_r     <= S_DONE;
                  end else begin
                     cap_r <= cap_r + CAP_ONE;
                  end
               end else begin
                  ph_r <= ph_r + LAT_ONE;
               end
            end
            default: begin
               state_r     <= S_IDLE;
               chain_din_r <= 1'b0;
               busy_r      <= 1'b0;
               done_r      <= 1'b0;
            end
         endcase
      end
   end

   assign chain_din = chain_din_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign latency   = latency_r;
   assign err_cnt   = err_cnt_r;
   assign timeout   = timeout_r;
   assign stuck     = stuck_r;

endmodule

// File: tb/tb_chain_checker.sv
// Directed bench for chain_checker: loopback, 128-flop chain, injected bit
// errors, stuck chains, reset/start interplay and error-count saturation.
module tb_chain_checker;

   logic        clk = 1'b0;
   logic        rst, start, start2;
   logic        chain_din, chain_dout, busy, done, timeout, stuck;
   logic [7:0]  latency;
   logic [15:0] err_cnt;
   logic        chain_din2, chain_dout2, busy2, done2, timeout2, stuck2;
   logic [7:0]  latency2;
   logic [3:0]  err2;

   int           mode;          // 0 wire, 1 128-flop chain, 2 tied high, 3 tied low
   logic [127:0] sr = '0;
   logic         flip = 1'b0;
   logic         rnd_en = 1'b0;
   logic         rnd = 1'b0;
   int           n_cmp = 0;
   int           n_err = 0;
   int           bcnt, emid, i, sat_mid;
   logic [31:0]  rtmp;

   always #5 clk = ~clk;

   always @(posedge clk) sr <= {sr[126:0], chain_din};

   assign chain_dout  = (mode == 0) ? chain_din :
                        (mode == 1) ? (sr[127] ^ flip) : (mode == 2);
   assign chain_dout2 = rnd_en ? rnd : chain_din2;

   chain_checker dut (
      .clk(clk), .rst(rst), .start(start), .chain_dout(chain_dout),
      .chain_din(chain_din), .busy(busy), .done(done), .latency(latency),
      .err_cnt(err_cnt), .timeout(timeout), .stuck(stuck)
   );

   chain_checker #(.ERR_W(4)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .chain_dout(chain_dout2),
      .chain_din(chain_din2), .busy(busy2), .done(done2), .latency(latency2),
      .err_cnt(err2), .timeout(timeout2), .stuck(stuck2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Pulse start, then track busy cycles until done; loop index i is the
   // negedge after edge k+i where k is the edge that samples start.
   task automatic run(input int poke, input int fa, input int fb, input int chk_at,
                      output int nb, output int em);
      int k;
      nb = 0;
      em = -1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (done !== 1'b1 && k < 4000) begin
         if (busy === 1'b1) nb++;
         if (k == chk_at) em = int'(err_cnt);
         start = (k == poke);
         flip  = (k == fa) || (k == fb);
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      flip  = 1'b0;
      check("run_finished", 32'(k < 4000), 32'd1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; start2 = 1'b0; mode = 0;
      repeat (3) @(negedge clk);
      check("rst_din", 32'(chain_din), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_lat", 32'(latency), 32'd0);
      check("rst_err", 32'(err_cnt), 32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);
      check("rst_stuck", 32'(stuck), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // wire loopback: 256 + 1 + 1 + 1024 busy cycles
      mode = 0;
      run(-1, -1, -1, -1, bcnt, emid);
      check("wire_lat", 32'(latency), 32'd0);
      check("wire_err", 32'(err_cnt), 32'd0);
      check("wire_timeout", 32'(timeout), 32'd0);
      check("wire_stuck", 32'(stuck), 32'd0);
      check("wire_done", 32'(done), 32'd1);
      check("wire_busy", 32'(bcnt), 32'd1282);

      // 128-flop chain, with a start pulse landing in WAIT
      mode = 1;
      run(259, -1, -1, -1, bcnt, emid);
      check("c128_lat", 32'(latency), 32'd128);
      check("c128_err", 32'(err_cnt), 32'd0);
      check("c128_busy", 32'(bcnt), 32'd1538);

      // restart from DONE with inversions at checked bit 500 and 20 bits later
      run(-1, 1020, 1040, 1035, bcnt, emid);
      check("flip1_err", 32'(emid), 32'd3);
      check("flip2_err", 32'(err_cnt), 32'd6);
      check("flip_lat", 32'(latency), 32'd128);

      run(-1, -1, -1, -1, bcnt, emid);
      check("rerun_lat", 32'(latency), 32'd128);
      check("rerun_err", 32'(err_cnt), 32'd0);
      check("rerun_busy", 32'(bcnt), 32'd1538);

      // reset during PRBS
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (600) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mrst_din", 32'(chain_din), 32'd0);
      check("mrst_busy", 32'(busy), 32'd0);
      check("mrst_done", 32'(done), 32'd0);
      check("mrst_lat", 32'(latency), 32'd0);
      check("mrst_err", 32'(err_cnt), 32'd0);
      check("mrst_timeout", 32'(timeout), 32'd0);
      check("mrst_stuck", 32'(stuck), 32'd0);
      repeat (5) @(negedge clk);
      check("mrst_idle", 32'(busy), 32'd0);

      // start together with reset: reset wins
      start = 1'b1; rst = 1'b1;
      @(negedge clk);
      start = 1'b0; rst = 1'b0;
      check("rst_start_busy", 32'(busy), 32'd0);
      @(negedge clk);
      check("rst_start_idle", 32'(busy), 32'd0);

      run(-1, -1, -1, -1, bcnt, emid);
      check("postrst_lat", 32'(latency), 32'd128);
      check("postrst_err", 32'(err_cnt), 32'd0);

      // chain output stuck high
      mode = 2;
      run(-1, -1, -1, -1, bcnt, emid);
      check("st1_stuck", 32'(stuck), 32'd1);
      check("st1_done", 32'(done), 32'd1);
      check("st1_err", 32'(err_cnt), 32'd0);
      check("st1_timeout", 32'(timeout), 32'd0);
      check("st1_busy", 32'(bcnt), 32'd256);

      // chain output stuck low
      mode = 3;
      run(-1, -1, -1, -1, bcnt, emid);
      check("st0_timeout", 32'(timeout), 32'd1);
      check("st0_lat", 32'(latency), 32'd255);
      check("st0_stuck", 32'(stuck), 32'd0);
      check("st0_busy", 32'(bcnt), 32'd513);

      // 4-bit error counter fed a random stream once PRBS is running
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      i = 0;
      sat_mid = -1;
      while (done2 !== 1'b1 && i < 4000) begin
         rtmp = $urandom;
         rnd_en = (i >= 300);
         rnd = rtmp[0];
         if (i == 900) sat_mid = int'(err2);
         @(negedge clk);
         i++;
      end
      rnd_en = 1'b0;
      check("sat_finished", 32'(i < 4000), 32'd1);
      check("sat_mid", 32'(sat_mid), 32'd15);
      check("sat_end", 32'(err2), 32'd15);
      check("sat_lat", 32'(latency2), 32'd0);
      check("sat_flags", 32'({timeout2, stuck2, busy2}), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
